// File: rtl/pwm_pkg.sv
// pwm_pkg - shared types, constants and helpers for the PWM timebase.
//
// Contents:
//   pwm_mode_e        counting mode of one channel (edge-aligned / center-aligned)
//   PWM_MIN_PERIOD_*  smallest period that still produces a well-formed waveform
//   pwm_clamp_period  maps a requested period onto the period actually used
package pwm_pkg;

    typedef enum logic {
        PWM_MODE_EDGE   = 1'b0,
        PWM_MODE_CENTER = 1'b1
    } pwm_mode_e;

    localparam int PWM_MIN_PERIOD_EDGE   = 2;
    localparam int PWM_MIN_PERIOD_CENTER = 3;

    // Works on 64-bit values so one function serves every counter width; the
    // caller zero-extends its operand and truncates the result back.
    // A zero request selects the default, which is clamped like any other value.
    function automatic logic [63:0] pwm_clamp_period(input logic [63:0] period,
                                                     input logic [63:0] dflt,
                                                     input pwm_mode_e   mode);
        logic [63:0] p;
        logic [63:0] pmin;
        p    = (period == 64'd0) ? dflt : period;
        pmin = (mode == PWM_MODE_CENTER) ? 64'(PWM_MIN_PERIOD_CENTER)
                                         : 64'(PWM_MIN_PERIOD_EDGE);
        if (p < pmin) begin
            p = pmin;
        end
        return p;
    endfunction

endpackage

// File: rtl/pwm_timebase_mc_channel.sv
// pwm_tb_channel - one PWM timebase channel: shadowed period/mode, counter and
// period boundary pulses.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   enable          run enable; while low the channel idles at 0 and tracks
//                   the requested period/mode in its shadow registers
//   center_mode     requested mode (1 = center-aligned)
//   period_cycles   requested period in ticks (clamped before use)
//   tick            shared count enable
//   sync_restart    restart to 0 and reload shadows
//   cnt, dir_down   current count and down-phase flag (0 while disabled)
//   period_start    first tick of a period (combinational)
//   period_end      last tick of a period (combinational)
//   period_eff      active (shadowed, clamped) period
module pwm_tb_channel
    import pwm_pkg::*;
#(
    parameter int CNT_WIDTH             = 32,
    parameter int DEFAULT_PERIOD_CYCLES = 5000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 center_mode,
    input  logic [CNT_WIDTH-1:0] period_cycles,
    input  logic                 tick,
    input  logic                 sync_restart,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 dir_down,
    output logic                 period_start,
    output logic                 period_end,
    output logic [CNT_WIDTH-1:0] period_eff
);

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TWO = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0] PER_RST =
        CNT_WIDTH'(pwm_clamp_period(64'(DEFAULT_PERIOD_CYCLES),
                                    64'(DEFAULT_PERIOD_CYCLES), PWM_MODE_EDGE));

    pwm_mode_e            cand_mode;
    pwm_mode_e            mode_q;
    logic [CNT_WIDTH-1:0] cand_per;
    logic [CNT_WIDTH-1:0] per_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 dir_q;
    logic                 dir_d;
    logic                 at_top;
    logic                 at_bottom;
    logic                 end_c;
    logic                 start_c;

    always_comb begin
        cand_mode = center_mode ? PWM_MODE_CENTER : PWM_MODE_EDGE;
        cand_per  = CNT_WIDTH'(pwm_clamp_period(64'(period_cycles),
                                                64'(DEFAULT_PERIOD_CYCLES), cand_mode));
    end

    // ">=" / "<=" rather than "==" keep the counter bounded by P-1 even if the
    // active period were ever smaller than the current count.
    always_comb begin
        at_top    = (cnt_q >= (per_q - ONE));
        at_bottom = (cnt_q <= ONE);
        end_c     = enable & tick & ((mode_q == PWM_MODE_CENTER) ? (dir_q & at_bottom) : at_top);
        start_c   = enable & tick & (cnt_q == '0) & ~dir_q;
    end

    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (mode_q == PWM_MODE_CENTER) begin
            if (!dir_q) begin
                if (at_top) begin
                    cnt_d = per_q - TWO;
                    dir_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end else if (at_bottom) begin
                cnt_d = '0;
                dir_d = 1'b0;
            end else begin
                cnt_d = cnt_q - ONE;
            end
        end else begin
            cnt_d = at_top ? '0 : (cnt_q + ONE);
            dir_d = 1'b0;
        end
    end

    // Shadow reload happens only where the counter restarts from 0 (disable,
    // restart, period end), so a new period never truncates the current one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            dir_q  <= 1'b0;
            per_q  <= PER_RST;
            mode_q <= PWM_MODE_EDGE;
        end else if (!enable) begin
            cnt_q  <= '0;
            dir_q  <= 1'b0;
            per_q  <= cand_per;
            mode_q <= cand_mode;
        end else if (sync_restart) begin
            cnt_q  <= '0;
            dir_q  <= 1'b0;
            per_q  <= cand_per;
            mode_q <= cand_mode;
        end else if (tick) begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
            if (end_c) begin
                per_q  <= cand_per;
                mode_q <= cand_mode;
            end
        end
    end

    // Gating on enable makes a disabled channel read 0 from the first cycle.
    assign cnt          = enable ? cnt_q : '0;
    assign dir_down     = enable & dir_q;
    assign period_start = start_c;
    assign period_end   = end_c;
    assign period_eff   = per_q;

endmodule

// File: rtl/pwm_timebase_mc.sv
// pwm_timebase_mc - multi-channel PWM timebase with double-buffered periods.
//
// Optional feature: define PWM_TB_PRESCALER_EN to add the shared prescaler
// and the psc_div port; otherwise every clock is a count tick.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   enable          per-channel run enable
//   center_mode     per-channel mode request (1 = center-aligned)
//   period_cycles   per-channel period request, in ticks
//   sync_restart    one-cycle pulse restarting all enabled channels
//   psc_div         tick every psc_div+1 clocks (PWM_TB_PRESCALER_EN only)
//   cnt             per-channel count
//   dir_down        per-channel down-phase flag
//   period_start    per-channel first tick of a period
//   period_end      per-channel last tick of a period
//   period_eff      per-channel active period
module pwm_timebase_mc
    import pwm_pkg::*;
#(
    parameter int CNT_WIDTH             = 32,
    parameter int NUM_CH                = 4,
    parameter int DEFAULT_PERIOD_CYCLES = 5000,
    parameter int PSC_WIDTH             = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_CH-1:0]                 enable,
    input  logic [NUM_CH-1:0]                 center_mode,
    input  logic [NUM_CH-1:0][CNT_WIDTH-1:0]  period_cycles,
    input  logic                              sync_restart,
`ifdef PWM_TB_PRESCALER_EN
    input  logic [PSC_WIDTH-1:0]              psc_div,
`endif
    output logic [NUM_CH-1:0][CNT_WIDTH-1:0]  cnt,
    output logic [NUM_CH-1:0]                 dir_down,
    output logic [NUM_CH-1:0]                 period_start,
    output logic [NUM_CH-1:0]                 period_end,
    output logic [NUM_CH-1:0][CNT_WIDTH-1:0]  period_eff
);

    logic tick;

`ifdef PWM_TB_PRESCALER_EN
    logic [PSC_WIDTH-1:0] psc_cnt_q;
    logic [PSC_WIDTH-1:0] psc_div_q;
    logic [PSC_WIDTH-1:0] psc_lim;

    // The divisor is captured on the first clock of each prescaler period;
    // that same clock compares against the live value so a new divisor
    // governs the whole period it starts.
    always_comb begin
        psc_lim = (psc_cnt_q == '0) ? psc_div : psc_div_q;
    end

    assign tick = (psc_cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_cnt_q <= '0;
            psc_div_q <= '0;
        end else if (sync_restart) begin
            psc_cnt_q <= '0;
        end else begin
            if (psc_cnt_q == '0) begin
                psc_div_q <= psc_div;
            end
            psc_cnt_q <= (psc_cnt_q >= psc_lim) ? '0 : (psc_cnt_q + PSC_WIDTH'(1));
        end
    end
`else
    // Constant 1 for any legal prescaler width.
    assign tick = (PSC_WIDTH > 0);
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_tb_channel #(
            .CNT_WIDTH             (CNT_WIDTH),
            .DEFAULT_PERIOD_CYCLES (DEFAULT_PERIOD_CYCLES)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .enable        (enable[i]),
            .center_mode   (center_mode[i]),
            .period_cycles (period_cycles[i]),
            .tick          (tick),
            .sync_restart  (sync_restart),
            .cnt           (cnt[i]),
            .dir_down      (dir_down[i]),
            .period_start  (period_start[i]),
            .period_end    (period_end[i]),
            .period_eff    (period_eff[i])
        );
    end

endmodule

// File: tb/tb_pwm_timebase_mc.sv
// tb_pwm_timebase_mc - directed self-checking bench for pwm_timebase_mc.
// Inputs change 2 ns after a rising edge; outputs are sampled 1 ns later.
module tb_pwm_timebase_mc;

    localparam int CW = 32;
    localparam int NC = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NC-1:0]         enable;
    logic [NC-1:0]         center_mode;
    logic [NC-1:0][CW-1:0] period_cycles;
    logic                  sync_restart;
`ifdef PWM_TB_PRESCALER_EN
    logic [15:0]           psc_div;
`endif
    logic [NC-1:0][CW-1:0] cnt;
    logic [NC-1:0]         dir_down;
    logic [NC-1:0]         period_start;
    logic [NC-1:0]         period_end;
    logic [NC-1:0][CW-1:0] period_eff;

    int n_tests = 0;
    int n_fail  = 0;

    int c1_cnt [4] = '{0, 1, 2, 1};
    int c1_dir [4] = '{0, 0, 0, 1};

    always #5 clk = ~clk;

    pwm_timebase_mc #(
        .CNT_WIDTH             (CW),
        .NUM_CH                (NC),
        .DEFAULT_PERIOD_CYCLES (5000),
        .PSC_WIDTH             (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .center_mode   (center_mode),
        .period_cycles (period_cycles),
        .sync_restart  (sync_restart),
`ifdef PWM_TB_PRESCALER_EN
        .psc_div       (psc_div),
`endif
        .cnt           (cnt),
        .dir_down      (dir_down),
        .period_start  (period_start),
        .period_end    (period_end),
        .period_eff    (period_eff)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n         = 1'b0;
        enable        = '0;
        center_mode   = '0;
        period_cycles = '0;
        sync_restart  = 1'b0;
`ifdef PWM_TB_PRESCALER_EN
        psc_div       = '0;
`endif
        // reset state
        #12;
        chk("rst_cnt0", 64'(cnt[0]), 64'd0);
        chk("rst_dir", 64'(dir_down), 64'd0);
        chk("rst_start", 64'(period_start), 64'd0);
        chk("rst_end", 64'(period_end), 64'd0);
        chk("rst_eff0", 64'(period_eff[0]), 64'd5000);
        cyc();
        rst_n = 1'b1;

        // shadows follow requests while disabled; clamp cases
        period_cycles[0] = 32'd4;
        period_cycles[1] = 32'd3;
        center_mode[1]   = 1'b1;
        period_cycles[2] = 32'd0;
        period_cycles[3] = 32'd1;
        cyc();
        #1;
        chk("eff0_p4", 64'(period_eff[0]), 64'd4);
        chk("eff1_p3c", 64'(period_eff[1]), 64'd3);
        chk("clamp_p0", 64'(period_eff[2]), 64'd5000);
        chk("clamp_p1_edge", 64'(period_eff[3]), 64'd2);
        period_cycles[3] = 32'd2;
        center_mode[3]   = 1'b1;
        cyc();
        #1;
        chk("clamp_p2_center", 64'(period_eff[3]), 64'd3);

        // edge P=4 on ch0, center P=3 on ch1
        cyc();
        enable = 4'b0011;
        for (int k = 0; k < 12; k++) begin
            #1;
            chk($sformatf("edge_cnt k%0d", k), 64'(cnt[0]), 64'(k % 4));
            chk($sformatf("edge_start k%0d", k), 64'(period_start[0]), 64'((k % 4) == 0));
            chk($sformatf("edge_end k%0d", k), 64'(period_end[0]), 64'((k % 4) == 3));
            chk($sformatf("ctr_cnt k%0d", k), 64'(cnt[1]), 64'(c1_cnt[k % 4]));
            chk($sformatf("ctr_dir k%0d", k), 64'(dir_down[1]), 64'(c1_dir[k % 4]));
            chk($sformatf("ctr_start k%0d", k), 64'(period_start[1]), 64'((k % 4) == 0));
            chk($sformatf("ctr_end k%0d", k), 64'(period_end[1]), 64'((k % 4) == 3));
            chk($sformatf("dis_cnt2 k%0d", k), 64'(cnt[2]), 64'd0);
            cyc();
        end

        // line up ch0 at 7 and ch1 at 2, then restart
        enable           = '0;
        period_cycles[0] = 32'd10;
        cyc();
        enable = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            if (k == 5) enable = 4'b0011;
            #1;
            chk($sformatf("pre_sync_cnt0 k%0d", k), 64'(cnt[0]), 64'(k));
            if (k == 5) chk("en_rise_start1", 64'(period_start[1]), 64'd1);
            if (k < 7) cyc();
        end
        chk("pre_sync_cnt1", 64'(cnt[1]), 64'd2);
        chk("pre_sync_dir1", 64'(dir_down[1]), 64'd0);
        sync_restart = 1'b1;
        cyc();
        sync_restart = 1'b0;
        #1;
        chk("sync_cnt0", 64'(cnt[0]), 64'd0);
        chk("sync_cnt1", 64'(cnt[1]), 64'd0);
        chk("sync_dir1", 64'(dir_down[1]), 64'd0);
        chk("sync_cnt2_dis", 64'(cnt[2]), 64'd0);
        chk("sync_start0", 64'(period_start[0]), 64'd1);
        cyc();

        // shadow update: 10 -> 5 written at cnt 3
        for (int k = 1; k < 16; k++) begin
            if (k == 3) period_cycles[0] = 32'd5;
            #1;
            chk($sformatf("shadow_cnt k%0d", k), 64'(cnt[0]), 64'((k < 10) ? k : ((k - 10) % 5)));
            chk($sformatf("shadow_eff k%0d", k), 64'(period_eff[0]), 64'((k < 10) ? 10 : 5));
            chk($sformatf("shadow_end k%0d", k), 64'(period_end[0]), 64'((k == 9) || (k == 14)));
            cyc();
        end

        // period_end coinciding with sync_restart: one reload, cnt 0
        period_cycles[0] = 32'd6;
        cyc();
        cyc();
        cyc();
        #1;
        chk("coin_cnt_before", 64'(cnt[0]), 64'd4);
        chk("coin_end_before", 64'(period_end[0]), 64'd1);
        chk("coin_eff_before", 64'(period_eff[0]), 64'd5);
        sync_restart = 1'b1;
        cyc();
        sync_restart = 1'b0;
        #1;
        chk("coin_cnt_after", 64'(cnt[0]), 64'd0);
        chk("coin_eff_after", 64'(period_eff[0]), 64'd6);
        chk("coin_start_after", 64'(period_start[0]), 64'd1);
        cyc();
        #1;
        chk("coin_cnt_next", 64'(cnt[0]), 64'd1);

        // disabling mid-count zeroes the channel at once
        enable[0] = 1'b0;
        #1;
        chk("dis_cnt0", 64'(cnt[0]), 64'd0);
        chk("dis_start0", 64'(period_start[0]), 64'd0);
        chk("dis_end0", 64'(period_end[0]), 64'd0);
        cyc();
        #1;
        chk("dis_cnt0_hold", 64'(cnt[0]), 64'd0);

        // asynchronous reset mid-period, then resume
        rst_n = 1'b0;
        #1;
        chk("amid_rst_cnt1", 64'(cnt[1]), 64'd0);
        chk("amid_rst_dir", 64'(dir_down), 64'd0);
        chk("amid_rst_eff1", 64'(period_eff[1]), 64'd5000);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("post_rst_cnt1", 64'(cnt[1]), 64'd0);
        chk("post_rst_start1", 64'(period_start[1]), 64'd1);
        cyc();
        #1;
        chk("post_rst_cnt1_next", 64'(cnt[1]), 64'd1);

`ifdef PWM_TB_PRESCALER_EN
        // prescaler: psc_div 2, edge P=2
        enable           = '0;
        center_mode[0]   = 1'b0;
        period_cycles[0] = 32'd2;
        psc_div          = 16'd2;
        cyc();
        enable       = 4'b0001;
        sync_restart = 1'b1;
        cyc();
        sync_restart = 1'b0;
        for (int j = 0; j < 9; j++) begin
            #1;
            chk($sformatf("psc_cnt j%0d", j), 64'(cnt[0]), 64'((j / 3) % 2));
            chk($sformatf("psc_end j%0d", j), 64'(period_end[0]), 64'(((j % 3) == 0) && (((j / 3) % 2) == 1)));
            chk($sformatf("psc_start j%0d", j), 64'(period_start[0]), 64'(((j % 3) == 0) && (((j / 3) % 2) == 0)));
            cyc();
        end
        rst_n = 1'b0;
        #1;
        chk("psc_rst_cnt0", 64'(cnt[0]), 64'd0);
        chk("psc_rst_eff0", 64'(period_eff[0]), 64'd5000);
        chk("psc_rst_end", 64'(period_end), 64'd0);
        cyc();
        rst_n = 1'b1;
`endif

        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
